// File: rtl/run_counter_pkg.sv
// Shared state encoding for the lookahead run counter.
package run_counter_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/cla_inc_dec.sv
// Combinational +1/-1 step with group carry-lookahead; cout flags overflow (up) or underflow (down).
module cla_inc_dec #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int unsigned NumGroups = WIDTH / GROUP;

  logic [WIDTH-1:0]     t;
  logic [NumGroups-1:0] grp_p;
  logic [NumGroups:0]   grp_c;
  logic                 bit_c;

  always_comb begin
    // A bit propagates the step when it is 1 going up, or 0 going down.
    t = dir ? in : ~in;

    grp_p = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      grp_p[g] = &t[g*GROUP +: GROUP];
    end

    // Each group carry-in is the flat AND of all lower group propagates.
    grp_c = '0;
    for (int unsigned g = 0; g <= NumGroups; g++) begin
      grp_c[g] = 1'b1;
      for (int unsigned k = 0; k < g; k++) begin
        grp_c[g] = grp_c[g] & grp_p[k];
      end
    end

    out   = '0;
    bit_c = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bit_c = grp_c[i/GROUP];
      for (int unsigned j = (i/GROUP)*GROUP; j < i; j++) begin
        bit_c = bit_c & t[j];
      end
      out[i] = in[i] ^ bit_c;
    end

    cout = grp_c[NumGroups];
  end

endmodule

// File: rtl/lookahead_run_counter.sv
// Run counter: loads a start value, steps up/down while enabled, pulses done at the limit.
module lookahead_run_counter
  import run_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned GROUP    = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             en,
  input  logic             abort,
  input  logic             clr_sat,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             sat
);

  localparam bit Clamp = (SATURATE != 0);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic             sat_q;
  logic [WIDTH-1:0] step_val;
  logic             step_ovf;

  cla_inc_dec #(
    .WIDTH(WIDTH),
    .GROUP(GROUP)
  ) u_step (
    .in  (count_q),
    .dir (up),
    .out (step_val),
    .cout(step_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      // A clamp later in this block overrides the clear.
      if (clr_sat) begin
        sat_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q <= start_val;
            state_q <= (start_val == limit) ? StDone : StRun;
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (en) begin
            if (step_ovf && Clamp) begin
              sat_q <= 1'b1;
              if (count_q == limit) begin
                state_q <= StDone;
              end
            end else begin
              count_q <= step_val;
              wrap_q  <= step_ovf;
              if (step_val == limit) begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign wrap  = wrap_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_lookahead_run_counter.sv
// Directed bench: a wrapping and a saturating counter driven with shared stimulus.
module tb_lookahead_run_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] start_val;
  logic [7:0] limit;
  logic       up;
  logic       en;
  logic       abort;
  logic       clr_sat;

  logic [7:0] count0, count1;
  logic       busy0, busy1, done0, done1, wrap0, wrap1, sat0, sat1;

  int n_checks;
  int n_errors;

  lookahead_run_counter #(.WIDTH(8), .GROUP(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .start_val(start_val), .limit(limit),
    .up(up), .en(en), .abort(abort), .clr_sat(clr_sat),
    .count(count0), .busy(busy0), .done(done0), .wrap(wrap0), .sat(sat0)
  );

  lookahead_run_counter #(.WIDTH(8), .GROUP(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .start_val(start_val), .limit(limit),
    .up(up), .en(en), .abort(abort), .clr_sat(clr_sat),
    .count(count1), .busy(busy1), .done(done1), .wrap(wrap1), .sat(sat1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_val = 8'h00; limit = 8'h00;
    up = 1'b1; en = 1'b0; abort = 1'b0; clr_sat = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (count0 !== 8'h00) begin n_errors++; $display("FAIL reset_count got %h want 00", count0); end
    n_checks++; if ({busy0, done0, wrap0, sat0} !== 4'b0) begin n_errors++; $display("FAIL reset_flags0 got %b want 0000", {busy0, done0, wrap0, sat0}); end
    n_checks++; if ({count1, busy1, done1, wrap1, sat1} !== 12'h0) begin n_errors++; $display("FAIL reset_dut_sat got %h want 000", {count1, busy1, done1, wrap1, sat1}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_count_up();
    logic [7:0] exp_cnt [5] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    logic       exp_bsy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_dn  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_val = 8'h05; limit = 8'h09; up = 1'b1; en = 1'b1; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      start = 1'b0;
      n_checks++;
      if ({count0, busy0, done0} !== {exp_cnt[k], exp_bsy[k], exp_dn[k]}) begin
        n_errors++;
        $display("FAIL up_step%0d got cnt=%h busy=%b done=%b want cnt=%h busy=%b done=%b",
                 k, count0, busy0, done0, exp_cnt[k], exp_bsy[k], exp_dn[k]);
      end
    end
    tick();
    n_checks++; if ({count0, busy0, done0} !== {8'h09, 2'b00}) begin n_errors++; $display("FAIL up_idle got cnt=%h busy=%b done=%b want 09 0 0", count0, busy0, done0); end
  endtask

  task automatic test_wrap_up();
    start_val = 8'hFE; limit = 8'h01; up = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++; if ({count0, wrap0} !== {8'hFF, 1'b0}) begin n_errors++; $display("FAIL wrap_ff got %h/%b want FF/0", count0, wrap0); end
    tick();
    n_checks++; if ({count0, wrap0, busy0, done0} !== {8'h00, 3'b110}) begin n_errors++; $display("FAIL wrap_00 got %h/%b%b%b want 00/110", count0, wrap0, busy0, done0); end
    n_checks++; if ({count1, sat1, busy1, wrap1} !== {8'hFF, 3'b110}) begin n_errors++; $display("FAIL sat_up_clamp got %h/%b%b%b want FF/110", count1, sat1, busy1, wrap1); end
    tick();
    n_checks++; if ({count0, wrap0, done0} !== {8'h01, 2'b01}) begin n_errors++; $display("FAIL wrap_done got %h/%b%b want 01/01", count0, wrap0, done0); end
    abort = 1'b1;
    tick();
    abort = 1'b0; clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    n_checks++; if ({busy0, busy1, done1, sat1} !== 4'b0) begin n_errors++; $display("FAIL wrap_cleanup got %b want 0000", {busy0, busy1, done1, sat1}); end
  endtask

  task automatic test_saturate_down();
    start_val = 8'h02; limit = 8'hF0; up = 1'b0; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++; if (count1 !== 8'h01) begin n_errors++; $display("FAIL sat_dn_01 got %h want 01", count1); end
    tick();
    n_checks++; if ({count1, sat1} !== {8'h00, 1'b0}) begin n_errors++; $display("FAIL sat_dn_00 got %h/%b want 00/0", count1, sat1); end
    tick();
    n_checks++; if ({count1, sat1, busy1, wrap1} !== {8'h00, 3'b110}) begin n_errors++; $display("FAIL sat_dn_clamp got %h/%b%b%b want 00/110", count1, sat1, busy1, wrap1); end
    n_checks++; if ({count0, wrap0} !== {8'hFF, 1'b1}) begin n_errors++; $display("FAIL wrap_dn got %h/%b want FF/1", count0, wrap0); end
    tick();
    n_checks++; if ({count1, busy1, done1} !== {8'h00, 2'b10}) begin n_errors++; $display("FAIL sat_dn_hold got %h/%b%b want 00/10", count1, busy1, done1); end
    abort = 1'b1; en = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({count1, busy1, done1, sat1} !== {8'h00, 3'b001}) begin n_errors++; $display("FAIL sat_abort got %h/%b%b%b want 00/001", count1, busy1, done1, sat1); end
    clr_sat = 1'b1;
    tick();
    clr_sat = 1'b0;
    n_checks++; if (sat1 !== 1'b0) begin n_errors++; $display("FAIL sat_clear got %b want 0", sat1); end
  endtask

  task automatic test_immediate_and_en();
    start_val = 8'h3C; limit = 8'h3C; up = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({count0, busy0, done0} !== {8'h3C, 2'b01}) begin n_errors++; $display("FAIL imm_done got %h/%b%b want 3C/01", count0, busy0, done0); end
    tick();
    n_checks++; if ({busy0, done0} !== 2'b00) begin n_errors++; $display("FAIL imm_idle got %b%b want 00", busy0, done0); end
    start_val = 8'h10; limit = 8'h20; start = 1'b1;
    tick();
    start_val = 8'h55; en = 1'b1;
    tick();
    n_checks++; if ({count0, busy0} !== {8'h11, 1'b1}) begin n_errors++; $display("FAIL en1_step got %h/%b want 11/1", count0, busy0); end
    en = 1'b0;
    tick();
    n_checks++; if ({count0, busy0} !== {8'h11, 1'b1}) begin n_errors++; $display("FAIL en0_hold got %h/%b want 11/1", count0, busy0); end
    en = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if ({count0, busy0} !== {8'h12, 1'b1}) begin n_errors++; $display("FAIL en1_again got %h/%b want 12/1", count0, busy0); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({count0, busy0, done0} !== {8'h12, 2'b00}) begin n_errors++; $display("FAIL en_abort got %h/%b%b want 12/00", count0, busy0, done0); end
  endtask

  task automatic test_reset_in_run();
    start_val = 8'h03; limit = 8'h20; up = 1'b1; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if ({count0, busy0} !== {8'h07, 1'b1}) begin n_errors++; $display("FAIL run_pre_rst got %h/%b want 07/1", count0, busy0); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if ({count0, busy0, done0} !== {8'h00, 2'b00}) begin n_errors++; $display("FAIL run_rst got %h/%b%b want 00/00", count0, busy0, done0); end
    tick();
    n_checks++; if ({count0, busy0, done0} !== {8'h00, 2'b00}) begin n_errors++; $display("FAIL run_rst_after got %h/%b%b want 00/00", count0, busy0, done0); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_saturate_down();
    test_immediate_and_en();
    test_reset_in_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
